// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: fetch PC, fixed-latency imem requests, prefetch FIFO.
// Optional backward-branch static prediction is enabled by defining IF_STATIC_PREDICT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        id_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o_IF,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        pred_taken_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc, next_fetch_pc;
  logic          inflight, inflight_kill;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          pop, push, issue, resp_ok, resp_pred;
  logic [CW:0]   credit;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];

  assign valid_o = (count != '0);
  assign pop     = valid_o && !id_stall_i;
  // Slots already committed (queued + in flight), minus the one ID frees this cycle.
  assign credit  = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue   = start && reset && !redirect_i && (credit < DEPTH_C);
  assign resp_ok = inflight && !inflight_kill;
  assign push    = resp_ok && !redirect_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc;

`ifdef IF_STATIC_PREDICT_EN
  logic [31:0] pred_target;
  logic        fifo_pred [FIFO_DEPTH];

  assign resp_pred   = resp_ok && (imem_rdata_i[6:0] == 7'b1100011) && imem_rdata_i[31];
  assign pred_target = inflight_pc + {{20{imem_rdata_i[31]}}, imem_rdata_i[7],
                                      imem_rdata_i[30:25], imem_rdata_i[11:8], 1'b0};
  assign pred_taken_o = valid_o ? fifo_pred[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) fifo_pred[wr_ptr] <= resp_pred;
  end
`else
  assign resp_pred    = 1'b0;
  assign pred_taken_o = 1'b0;
`endif

  always_comb begin
    next_fetch_pc = fetch_pc;
    if (redirect_i)
      next_fetch_pc = {redirect_pc_i[31:2], 2'b00};
`ifdef IF_STATIC_PREDICT_EN
    else if (resp_pred)
      next_fetch_pc = pred_target;
`endif
    else if (issue)
      next_fetch_pc = fetch_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_pc   <= '0;
      inflight_kill <= 1'b0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      fetch_pc      <= next_fetch_pc;
      inflight      <= issue;
      inflight_kill <= issue && resp_pred;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  assign inst_o_IF = valid_o ? fifo_inst[rd_ptr] : NOP_INST;
  assign pc_o      = valid_o ? fifo_pc[rd_ptr]   : 32'h0;

endmodule
